// File: rtl/intpol2_pkg.sv
// Shared defaults and status-bit indices for the interpolator IQ FIFO.
package intpol2_pkg;

  localparam int unsigned DEF_DATAPATH_WIDTH  = 12;
  localparam int unsigned DEF_FIFO_ADDR_WIDTH = 4;
  localparam int unsigned DEF_AFULL_MARGIN    = 2;

  localparam int unsigned STAT_OVF = 0;
  localparam int unsigned STAT_UDF = 1;

  function automatic logic afull_of(input int unsigned depth,
                                    input int unsigned occ,
                                    input int unsigned margin);
    return (depth - occ) <= margin;
  endfunction

endpackage

// File: rtl/intpol2_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module intpol2_fifo_ram #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/intpol2_iq_fifo.sv
// First-word-fall-through IQ sample FIFO with registered flags and sticky status.
// Define DUAL_DATAPATH_EN to store and expose the Q channel alongside I.
module intpol2_iq_fifo
  import intpol2_pkg::*;
#(
  parameter int unsigned DATAPATH_WIDTH  = DEF_DATAPATH_WIDTH,
  parameter int unsigned FIFO_ADDR_WIDTH = DEF_FIFO_ADDR_WIDTH,
  parameter int unsigned AFULL_MARGIN    = DEF_AFULL_MARGIN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      Write_Enable,
  input  logic [DATAPATH_WIDTH-1:0] data_in_1,
`ifdef DUAL_DATAPATH_EN
  input  logic [DATAPATH_WIDTH-1:0] data_in_2,
`endif
  input  logic                      Read_Enable,
  output logic [DATAPATH_WIDTH-1:0] data_out_1,
`ifdef DUAL_DATAPATH_EN
  output logic [DATAPATH_WIDTH-1:0] data_out_2,
`endif
  output logic                      Empty_o,
  output logic                      Full_o,
  output logic                      Afull_o,
  output logic [FIFO_ADDR_WIDTH:0]  count,
  output logic [1:0]                status
);

  localparam int unsigned PW    = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2**FIFO_ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_CNT = DEPTH[PW-1:0];
  localparam logic AFULL_RST = afull_of(DEPTH, 0, AFULL_MARGIN);
`ifdef DUAL_DATAPATH_EN
  localparam int unsigned MEM_W = 2 * DATAPATH_WIDTH;
`else
  localparam int unsigned MEM_W = DATAPATH_WIDTH;
`endif

  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic [1:0]       status_nxt;
  logic             push_acc, pop_acc, ovf, udf;
  logic [MEM_W-1:0] wdata, rdata;

`ifdef DUAL_DATAPATH_EN
  assign wdata      = {data_in_2, data_in_1};
  assign data_out_2 = rdata[MEM_W-1:DATAPATH_WIDTH];
`else
  assign wdata      = data_in_1;
`endif
  assign data_out_1 = rdata[DATAPATH_WIDTH-1:0];

  // Flags come from the next-state pointer difference so they land on the
  // same edge as the pointers themselves.
  always_comb begin
    pop_acc    = Read_Enable && !Empty_o;
    push_acc   = Write_Enable && (!Full_o || pop_acc);
    ovf        = Write_Enable && Full_o && !Read_Enable;
    udf        = Read_Enable && Empty_o;
    wr_ptr_nxt = wr_ptr + PW'(push_acc);
    rd_ptr_nxt = rd_ptr + PW'(pop_acc);
    status_nxt = status;
    status_nxt[STAT_OVF] = status[STAT_OVF] | ovf;
    status_nxt[STAT_UDF] = status[STAT_UDF] | udf;
    if (clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      status_nxt = '0;
    end
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      Empty_o <= 1'b1;
      Full_o  <= 1'b0;
      Afull_o <= AFULL_RST;
      status  <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      Empty_o <= (count_nxt == '0);
      Full_o  <= (count_nxt == DEPTH_CNT);
      Afull_o <= afull_of(DEPTH, 32'(count_nxt), AFULL_MARGIN);
      status  <= status_nxt;
    end
  end

  intpol2_fifo_ram #(
    .WIDTH (MEM_W),
    .AW    (FIFO_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_acc && !clear),
    .waddr (wr_ptr[FIFO_ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr[FIFO_ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_intpol2_iq_fifo.sv
// Scoreboard bench for intpol2_iq_fifo: directed pushes feed an expected queue,
// a negedge monitor checks every accepted pop; flags are checked directly.
module tb_intpol2_iq_fifo;

  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          Write_Enable = 1'b0;
  logic          Read_Enable = 1'b0;
  logic [DW-1:0] data_in_1 = '0;
  logic [DW-1:0] data_in_2 = '0;
  logic [DW-1:0] data_out_1;
  logic [DW-1:0] data_out_2;
  logic          Empty_o, Full_o, Afull_o;
  logic [4:0]    count;
  logic [1:0]    status;

  int total = 0;
  int bad = 0;
  logic [2*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  intpol2_iq_fifo #(
    .DATAPATH_WIDTH  (DW),
    .FIFO_ADDR_WIDTH (4),
    .AFULL_MARGIN    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .Write_Enable (Write_Enable),
    .data_in_1    (data_in_1),
`ifdef DUAL_DATAPATH_EN
    .data_in_2    (data_in_2),
`endif
    .Read_Enable  (Read_Enable),
    .data_out_1   (data_out_1),
`ifdef DUAL_DATAPATH_EN
    .data_out_2   (data_out_2),
`endif
    .Empty_o      (Empty_o),
    .Full_o       (Full_o),
    .Afull_o      (Afull_o),
    .count        (count),
    .status       (status)
  );

`ifndef DUAL_DATAPATH_EN
  assign data_out_2 = '0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; expect=1 records the push as one that must be accepted.
  task automatic drive(input logic we, input logic re, input logic [DW-1:0] i,
                       input logic [DW-1:0] q, input logic clr, input logic expect_push);
    Write_Enable = we;
    Read_Enable  = re;
    data_in_1    = i;
    data_in_2    = q;
    clear        = clr;
    if (expect_push) exp_q.push_back({q, i});
    @(posedge clk);
    #1;
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
    clear        = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [2*DW-1:0] e;
    if (!rst && !clear && Read_Enable && !Empty_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data", data_out_1);
      end else begin
        e = exp_q.pop_front();
        check("pop_i", 32'(data_out_1), 32'(e[DW-1:0]));
`ifdef DUAL_DATAPATH_EN
        check("pop_q", 32'(data_out_2), 32'(e[2*DW-1:DW]));
`endif
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_empty", 32'(Empty_o), 1);
    check("rst_full", 32'(Full_o), 0);
    check("rst_afull", 32'(Afull_o), 0);
    check("rst_count", 32'(count), 0);
    check("rst_status", 32'(status), 0);

    // First push becomes visible at the head one cycle later.
    drive(1, 0, 12'h123, 12'hF00, 0, 1);
    check("first_empty", 32'(Empty_o), 0);
    check("first_count", 32'(count), 1);
    check("first_i", 32'(data_out_1), 32'h123);
`ifdef DUAL_DATAPATH_EN
    check("first_q", 32'(data_out_2), 32'hF00);
`endif
    drive(0, 1, '0, '0, 0, 0);
    check("first_drained", 32'(Empty_o), 1);

    // Fill through almost-full and full, then overflow.
    for (int k = 0; k < 16; k++) begin
      drive(1, 0, 12'(12'h100 + k), 12'(12'h200 + k), 0, 1);
      if (k == 12) check("afull_13", 32'(Afull_o), 0);
      if (k == 13) begin
        check("afull_14", 32'(Afull_o), 1);
        check("count_14", 32'(count), 14);
        check("full_14", 32'(Full_o), 0);
      end
    end
    check("full_16", 32'(Full_o), 1);
    check("count_16", 32'(count), 16);
    drive(1, 0, 12'h1FF, 12'h2FF, 0, 0);
    check("ovf_count", 32'(count), 16);
    check("ovf_status", 32'(status), 2'b01);
    check("ovf_full", 32'(Full_o), 1);

    // Push and pop while full: both accepted.
    drive(1, 1, 12'h155, 12'h255, 0, 1);
    check("fullrw_count", 32'(count), 16);
    check("fullrw_full", 32'(Full_o), 1);
    for (int k = 0; k < 16; k++) drive(0, 1, '0, '0, 0, 0);
    check("drain_empty", 32'(Empty_o), 1);
    check("drain_count", 32'(count), 0);

    // Underflow, then pop+push on empty keeps the push.
    drive(0, 1, '0, '0, 0, 0);
    check("udf_status", 32'(status), 2'b11);
    check("udf_count", 32'(count), 0);
    drive(1, 1, 12'h7FF, 12'h0AA, 0, 1);
    check("udf_push_count", 32'(count), 1);
    check("udf_push_head", 32'(data_out_1), 32'h7FF);
    drive(0, 1, '0, '0, 0, 0);

    // Streaming 0..39 across pointer wrap.
    drive(1, 0, 12'd0, 12'd100, 0, 1);
    for (int k = 1; k < 40; k++) drive(1, 1, 12'(k), 12'(100 + k), 0, 1);
    check("stream_count", 32'(count), 1);
    drive(0, 1, '0, '0, 0, 0);
    check("stream_empty", 32'(Empty_o), 1);
    check("stream_status", 32'(status), 2'b11);

    // Clear with a concurrent push discards everything.
    for (int k = 0; k < 9; k++) drive(1, 0, 12'(12'h300 + k), 12'h000, 0, 1);
    check("pre_clear_count", 32'(count), 9);
    exp_q.delete();
    drive(1, 0, 12'h3AA, 12'h000, 1, 0);
    check("clear_count", 32'(count), 0);
    check("clear_empty", 32'(Empty_o), 1);
    check("clear_status", 32'(status), 0);
    drive(1, 0, 12'h3BB, 12'h4BB, 0, 1);
    drive(0, 1, '0, '0, 0, 0);

    // Reset mid-stream behaves like clear.
    for (int k = 0; k < 5; k++) drive(1, 0, 12'(12'h500 + k), 12'h000, 0, 1);
    exp_q.delete();
    rst = 1'b1;
    drive(1, 1, 12'h5AA, 12'h000, 0, 0);
    rst = 1'b0;
    check("rst2_count", 32'(count), 0);
    check("rst2_empty", 32'(Empty_o), 1);
    check("rst2_status", 32'(status), 0);
    drive(1, 0, 12'h0AB, 12'h0CD, 0, 1);
    check("rst2_head", 32'(data_out_1), 32'h0AB);
    drive(0, 1, '0, '0, 0, 0);

    repeat (2) @(posedge clk);
    #1 check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
